// File: rtl/sha256_msg_padder.sv
// -----------------------------------------------------------------------------
// sha256_msg_padder
//
// Producer side of the SHA-256 block interface. Collects a message arriving as
// big-endian 32-bit words, applies FIPS 180-4 padding (0x80 marker, zero fill,
// 64-bit big-endian bit length) and hands out 512-bit blocks over valid/ready.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   padder can accept a word this cycle
//   in_data    message word, earliest byte in [31:24]
//   in_last    final beat of the message
//   in_nbytes  valid (left-aligned) bytes in a last beat, 0..4 (5..7 act as 4)
//   blk_valid  blk_data holds a complete block
//   blk_ready  consumer accepts the block
//   blk_data   block; word k is blk_data[511-32k -: 32]
//   blk_first  block is the first of its message
//   blk_last   block is the final (padded) block of its message
//   busy       a message is in progress (word accepted, final block not taken)
// -----------------------------------------------------------------------------
module sha256_msg_padder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last,
    output logic         busy
);

    typedef enum logic {FILL, EMIT} state_t;

    state_t        state;
    logic [511:0]  buffer;
    logic [3:0]    word_idx;
    logic [63:0]   bitlen;
    logic [63:0]   stored_len;
    logic          start_flag;
    logic          last_f;
    logic          pend_len;
    logic          pend_mark;

    // Last-beat decode: effective byte count, byte position in block, total
    // length, and the buffer image after writing data, marker and length.
    logic [2:0]    n_eff;
    logic [6:0]    b_cnt;
    logic [63:0]   len_total;
    logic [31:0]   byte_mask;
    logic [8:0]    word_hi;
    logic [8:0]    mark_hi;
    logic [511:0]  last_buf;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        n_eff     = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
        b_cnt     = {1'b0, word_idx, 2'b00} + {4'b0000, n_eff};
        len_total = bitlen + {58'd0, n_eff, 3'b000};
        word_hi   = 9'd511 - {word_idx, 5'b00000};
        mark_hi   = 9'd511 - {b_cnt[5:0], 3'b000};
        case (n_eff)
            3'd0:    byte_mask = 32'h0000_0000;
            3'd1:    byte_mask = 32'hFF00_0000;
            3'd2:    byte_mask = 32'hFFFF_0000;
            3'd3:    byte_mask = 32'hFFFF_FF00;
            default: byte_mask = 32'hFFFF_FFFF;
        endcase
        last_buf = buffer;
        // Unused lanes are written as zero so the marker lands on clean bits.
        last_buf[word_hi -: 32] = in_data & byte_mask;
        if (b_cnt < 7'd64)
            last_buf[mark_hi -: 8] = 8'h80;
        if (b_cnt <= 7'd55)
            last_buf[63:0] = len_total;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the block buffer is reset because a reset must discard any pending
    // block and later blocks rely on untouched words being zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            in_ready   <= 1'b1;
            blk_valid  <= 1'b0;
            buffer     <= '0;
            word_idx   <= '0;
            bitlen     <= '0;
            stored_len <= '0;
            start_flag <= 1'b1;
            last_f     <= 1'b0;
            pend_len   <= 1'b0;
            pend_mark  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid && in_ready) begin
                        busy <= 1'b1;
                        if (!in_last) begin
                            buffer[word_hi -: 32] <= in_data;
                            bitlen   <= bitlen + 64'd32;
                            word_idx <= word_idx + 4'd1;
                            if (word_idx == 4'd15) begin
                                state     <= EMIT;
                                in_ready  <= 1'b0;
                                blk_valid <= 1'b1;
                                last_f    <= 1'b0;
                            end
                        end else begin
                            buffer     <= last_buf;
                            bitlen     <= len_total;
                            stored_len <= len_total;
                            if (b_cnt <= 7'd55) begin
                                last_f <= 1'b1;
                            end else begin
                                // Length (and maybe the marker) spills into an
                                // extra block emitted right after this one.
                                last_f    <= 1'b0;
                                pend_len  <= 1'b1;
                                pend_mark <= (b_cnt == 7'd64);
                            end
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                        end
                    end
                end

                EMIT: begin
                    if (blk_ready) begin
                        start_flag <= 1'b0;
                        if (pend_len) begin
                            buffer    <= {(pend_mark ? 32'h8000_0000 : 32'h0), 416'd0, stored_len};
                            last_f    <= 1'b1;
                            pend_len  <= 1'b0;
                            pend_mark <= 1'b0;
                        end else begin
                            buffer    <= '0;
                            state     <= FILL;
                            in_ready  <= 1'b1;
                            blk_valid <= 1'b0;
                            word_idx  <= '0;
                            if (last_f) begin
                                bitlen     <= '0;
                                start_flag <= 1'b1;
                                busy       <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    assign blk_data  = buffer;
    assign blk_first = blk_valid & start_flag;
    assign blk_last  = blk_valid & last_f;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_padder
//
// Self-checking bench for sha256_msg_padder. Messages are byte queues; the
// reference model pads them the textbook way (append 0x80, zero-fill to 56 mod
// 64, append the 64-bit bit length) and slices the result into 64-byte blocks.
// Directed boundary lengths come first, then randomized messages with random
// input gaps and consumer stalls.
// -----------------------------------------------------------------------------
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [2:0]   in_nbytes = '0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         busy;

    sha256_msg_padder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [7:0]   msg_q[$];
    blk_t         exp_q[$];
    logic [31:0]  beat_data[$];
    logic         beat_last[$];
    logic [2:0]   beat_n[$];
    logic [511:0] last_blk;

    task automatic check(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic add_random_bytes(input int len);
        for (int i = 0; i < len; i++)
            msg_q.push_back(8'($urandom));
    endtask

    // Reference model plus beat generation for the message in msg_q; both are
    // appended so several messages can be queued back-to-back.
    task automatic commit_msg(input bit zero_tail);
        logic [7:0]  pad[$];
        logic [63:0] bits;
        blk_t        b;
        logic [31:0] w;
        int          m;
        int          pos;
        int          r;
        int          nblk;

        pad  = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        pad.push_back(8'h80);
        while ((pad.size() % 64) != 56)
            pad.push_back(8'h00);
        for (int k = 7; k >= 0; k--)
            pad.push_back(bits[8*k +: 8]);
        nblk = pad.size() / 64;
        for (int i = 0; i < nblk; i++) begin
            b.data = '0;
            for (int j = 0; j < 64; j++)
                b.data[511 - 8*j -: 8] = pad[64*i + j];
            b.first = (i == 0);
            b.last  = (i == nblk - 1);
            exp_q.push_back(b);
        end

        m   = msg_q.size();
        pos = 0;
        while (m - pos > 4) begin
            w = {msg_q[pos], msg_q[pos+1], msg_q[pos+2], msg_q[pos+3]};
            beat_data.push_back(w); beat_last.push_back(1'b0); beat_n.push_back(3'd4);
            pos += 4;
        end
        r = m - pos;
        if (r == 4 && zero_tail) begin
            w = {msg_q[pos], msg_q[pos+1], msg_q[pos+2], msg_q[pos+3]};
            beat_data.push_back(w); beat_last.push_back(1'b0); beat_n.push_back(3'd4);
            beat_data.push_back($urandom); beat_last.push_back(1'b1); beat_n.push_back(3'd0);
        end else begin
            w = $urandom;
            for (int k = 0; k < r; k++)
                w[31 - 8*k -: 8] = msg_q[pos + k];
            beat_data.push_back(w);
            beat_last.push_back(1'b1);
            beat_n.push_back((r == 4) ? 3'(4 + $urandom_range(0, 3)) : 3'(r));
        end
        msg_q.delete();
    endtask

    // stall_mode: 0 always ready, 1 random ready, 2 hold ready low 5 cycles per block
    task automatic run_msgs(input int gap_pct, input int stall_mode);
        int           bi;
        int           cyc;
        int           stall;
        bit           held_v;
        logic [511:0] held_d;
        logic         held_f;
        logic         held_l;
        blk_t         e;

        bi = 0; cyc = 0; stall = 0; held_v = 0;
        held_d = '0; held_f = 0; held_l = 0;
        while ((exp_q.size() > 0 || bi < beat_data.size()) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (held_v) begin
                check("hold_valid", blk_valid, 1'b1);
                check("hold_data", blk_data, held_d);
                check("hold_first", blk_first, held_f);
                check("hold_last", blk_last, held_l);
                check("hold_in_ready", in_ready, 1'b0);
            end
            if (blk_valid)
                check("busy_emit", busy, 1'b1);

            case (stall_mode)
                0:       blk_ready = 1'b1;
                1:       blk_ready = 1'($urandom_range(0, 1));
                default: blk_ready = (stall >= 5);
            endcase

            if (bi < beat_data.size() && $urandom_range(0, 99) >= gap_pct) begin
                in_valid  = 1'b1;
                in_data   = beat_data[bi];
                in_last   = beat_last[bi];
                in_nbytes = beat_n[bi];
            end else begin
                in_valid  = 1'b0;
                in_data   = $urandom;
                in_last   = 1'($urandom);
                in_nbytes = 3'($urandom);
            end
            if (in_valid && in_ready)
                bi++;

            if (blk_valid && blk_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("blk_data", blk_data, e.data);
                    check("blk_first", blk_first, e.first);
                    check("blk_last", blk_last, e.last);
                end else begin
                    check("extra_block", 1'b1, 1'b0);
                end
                last_blk = blk_data;
                held_v = 0;
                stall  = 0;
            end else if (blk_valid) begin
                held_v = 1;
                held_d = blk_data;
                held_f = blk_first;
                held_l = blk_last;
                stall++;
            end else begin
                held_v = 0;
            end
        end
        check("timeout_blocks_left", 32'(exp_q.size()), 32'd0);
        check("timeout_beats_used", 32'(bi), 32'(beat_data.size()));
        exp_q.delete();
        beat_data.delete(); beat_last.delete(); beat_n.delete();
        @(negedge clk);
        in_valid  = 1'b0;
        blk_ready = 1'b0;
        check("idle_busy", busy, 1'b0);
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_blk_valid", blk_valid, 1'b0);
    endtask

    task automatic add_abc();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_blk_valid"}, blk_valid, 1'b0);
        check({tag, "_blk_first"}, blk_first, 1'b0);
        check({tag, "_blk_last"}, blk_last, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_blk_data"}, blk_data, 512'd0);
    endtask

    int dlen[11] = '{0, 3, 55, 56, 57, 60, 63, 64, 65, 119, 128};

    initial begin
        last_blk = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // "abc"
        add_abc();
        commit_msg(1'b0);
        run_msgs(0, 0);
        check("abc_word0", last_blk[511:480], 32'h6162_6380);
        check("abc_word15", last_blk[31:0], 32'h0000_0018);

        // Directed boundary lengths with stall patterns.
        for (int i = 0; i < 11; i++) begin
            add_random_bytes(dlen[i]);
            commit_msg(1'(i % 2));
            run_msgs(i * 3, i % 3);
        end

        // 64 bytes then "abc" back-to-back.
        add_random_bytes(64);
        commit_msg(1'b0);
        add_abc();
        commit_msg(1'b0);
        run_msgs(0, 0);
        check("b2b_abc_word15", last_blk[31:0], 32'h0000_0018);

        // Long consumer stall mid-message.
        add_random_bytes(100);
        commit_msg(1'b0);
        run_msgs(10, 2);

        // Reset after 7 accepted words.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = $urandom; in_last = 1'b0; in_nbytes = 3'd4;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_before_reset", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        add_abc();
        commit_msg(1'b0);
        run_msgs(0, 0);
        check("post_reset_abc", last_blk,
              {32'h6162_6380, 448'd0, 32'h0000_0018});

        // Randomized messages, sometimes two queued back-to-back.
        for (int t = 0; t < 14; t++) begin
            add_random_bytes($urandom_range(0, 200));
            commit_msg(1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                add_random_bytes($urandom_range(0, 80));
                commit_msg(1'($urandom));
            end
            run_msgs($urandom_range(0, 40), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
